// File: rtl/bolt_pkg.sv
// Shared opcode constants, FSM states and op classification
// for the bolt core load/store stage.
package bolt_pkg;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_U4  = 6'd4;
  localparam logic [5:0] OP_LBU = 6'd5;
  localparam logic [5:0] OP_LHU = 6'd6;
  localparam logic [5:0] OP_U7  = 6'd7;
  localparam logic [5:0] OP_SB  = 6'd18;
  localparam logic [5:0] OP_SH  = 6'd19;
  localparam logic [5:0] OP_SW  = 6'd20;
  localparam logic [5:0] OP_U21 = 6'd21;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_FIN
  } lsu_state_e;

  typedef enum logic [1:0] {
    K_PASS,
    K_LOAD,
    K_STORE,
    K_BAD
  } op_kind_e;

  // Misaligned and unsupported ops both collapse to K_BAD.
  function automatic op_kind_e op_kind(
    input logic [5:0] op,
    input logic [1:0] off
  );
    op_kind_e k;
    k = K_PASS;
    case (op)
      OP_LB, OP_LBU:        k = K_LOAD;
      OP_LH, OP_LHU:        k = off[0] ? K_BAD : K_LOAD;
      OP_LW:                k = (off != 2'b00) ? K_BAD : K_LOAD;
      OP_SB:                k = K_STORE;
      OP_SH:                k = off[0] ? K_BAD : K_STORE;
      OP_SW:                k = (off != 2'b00) ? K_BAD : K_STORE;
      OP_U4, OP_U7, OP_U21: k = K_BAD;
      default:              k = K_PASS;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane placement / byte enables and load byte/half
// extraction with sign or zero extension.
module lsu_align
  import bolt_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[{off, 3'b000} +: 8];
    half_sel  = off[1] ? rdata[31:16] : rdata[15:0];
    be        = 4'h0;
    wdata     = store_data;
    load_data = rdata;
    case (op)
      OP_SB: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      OP_SH: begin
        be    = 4'b0011 << off;
        wdata = {2{store_data[15:0]}};
      end
      OP_SW:  be = 4'hF;
      OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: load_data = {24'h0, byte_sel};
      OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU: load_data = {16'h0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one op at a time, data-memory handshake
// with watchdog abort, single-cycle writeback pulse.
module lsu
  import bolt_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  alu_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        done,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  lsu_state_e    state, state_nx;
  op_kind_e      kind;
  logic [5:0]    op_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic          fin_we;
  logic          fin_err;
  logic          accept;
  logic          timeout;
  logic          ld_done;
  logic          abort;
  logic [5:0]    al_op;
  logic [1:0]    al_off;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [31:0]   load_c;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign kind     = op_kind(alu_op, addr[1:0]);
  assign timeout  = (cnt >= CW'(MAX_WAIT - 1));

  // Stores are shaped at accept; loads are extracted from latched op.
  assign al_op  = in_ready ? alu_op : op_q;
  assign al_off = in_ready ? addr[1:0] : off_q;

  lsu_align u_align (
    .op         (al_op),
    .off        (al_off),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .load_data  (load_c)
  );

  assign ld_done = !we_q &&
    (((state == S_REQ) && dmem_gnt && dmem_rvalid) ||
     ((state == S_RESP) && dmem_rvalid));

  assign abort = timeout &&
    (((state == S_REQ) && !dmem_gnt) ||
     ((state == S_RESP) && !dmem_rvalid));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (accept)
          state_nx = (kind == K_LOAD || kind == K_STORE) ?
                     S_REQ : S_FIN;
      S_REQ:
        if (dmem_gnt)
          state_nx = (we_q || dmem_rvalid) ? S_FIN : S_RESP;
        else if (timeout)
          state_nx = S_FIN;
      S_RESP:
        if (dmem_rvalid || timeout)
          state_nx = S_FIN;
      S_FIN:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      cnt        <= '0;
      we_q       <= 1'b0;
      fin_we     <= 1'b0;
      fin_err    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      wb_data    <= '0;
      wb_rd      <= '0;
    end else begin
      state <= state_nx;
      if (state == S_REQ || state == S_RESP)
        cnt <= cnt + CW'(1);
      if (accept) begin
        cnt        <= '0;
        op_q       <= alu_op;
        off_q      <= addr[1:0];
        rd_q       <= rd_in;
        we_q       <= (kind == K_STORE);
        fin_we     <= (kind == K_PASS);
        fin_err    <= (kind == K_BAD);
        dmem_addr  <= {addr[31:2], 2'b00};
        dmem_wdata <= wdata_c;
        dmem_be    <= be_c;
        if (kind == K_PASS) begin
          wb_data <= addr;
          wb_rd   <= rd_in;
        end
      end
      if (ld_done) begin
        fin_we  <= 1'b1;
        wb_data <= load_c;
        wb_rd   <= rd_q;
      end
      if (abort)
        fin_err <= 1'b1;
    end
  end

  assign dmem_req = (state == S_REQ);
  assign dmem_we  = we_q;
  assign done     = (state == S_FIN);
  assign wb_we    = done && fin_we;
  assign err      = done && fin_err;

endmodule
